// File: rtl/fft_iter_addr_gen_if.sv
// Butterfly issue bus between the FFT address sequencer and the butterfly unit.
// master: sequencer side; slave: butterfly / stage-ring side.
interface fft_iter_addr_gen_if #(
    parameter int LOG2N = 10
);
    localparam int SW = ($clog2(LOG2N) > 0) ? $clog2(LOG2N) : 1;

    logic             i_START;
    logic             i_READY;
    logic             o_VALID;
    logic [LOG2N-1:0] o_ADDR_A;
    logic [LOG2N-1:0] o_ADDR_B;
    logic [LOG2N-2:0] o_TW_IDX;
    logic [SW-1:0]    o_STAGE;
    logic             o_STAGE_EN;
    logic             o_STAGE_RST;
    logic             o_BUSY;
    logic             o_DONE;

    modport master (
        input  i_START, i_READY,
        output o_VALID, o_ADDR_A, o_ADDR_B, o_TW_IDX, o_STAGE,
               o_STAGE_EN, o_STAGE_RST, o_BUSY, o_DONE
    );

    modport slave (
        output i_START, i_READY,
        input  o_VALID, o_ADDR_A, o_ADDR_B, o_TW_IDX, o_STAGE,
               o_STAGE_EN, o_STAGE_RST, o_BUSY, o_DONE
    );
endinterface

// File: rtl/fft_iter_addr_gen.sv
// Butterfly address / stage sequencer for the iterative radix-2 DIT FFT.
// Issues one butterfly (A, B, twiddle index) per handshake over LOG2N stages
// and drives the EN/RST pulses of the downstream one-hot stage ring.
// Optional feature macro: FFT_AG_STAGE_GAP_EN inserts GAP_CYCLES idle cycles
// between stages; without it, stages run back to back.
module fft_iter_addr_gen #(
    parameter int LOG2N      = 10,
    parameter int GAP_CYCLES = 4
) (
    input logic                 CLK,
    input logic                 RST,
    fft_iter_addr_gen_if.master bus
);
    localparam int KW = LOG2N - 1;
    localparam int SW = ($clog2(LOG2N) > 0) ? $clog2(LOG2N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
`ifdef FFT_AG_STAGE_GAP_EN
    localparam logic [1:0] GAP  = 2'd2;
`endif
    localparam logic [1:0] FIN  = 2'd3;

    if (LOG2N < 2 || LOG2N > 16) begin : g_bad_log2n
        $error("fft_iter_addr_gen: LOG2N must be in 2..16");
    end
    if (GAP_CYCLES < 1 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("fft_iter_addr_gen: GAP_CYCLES must be in 1..255");
    end

    logic [1:0]       state, state_nxt;
    logic [SW-1:0]    s, s_nxt;
    logic [KW-1:0]    k, k_nxt;
    logic             stage_en_nxt, stage_rst_nxt;
`ifdef FFT_AG_STAGE_GAP_EN
    logic [7:0]       gap_cnt, gap_nxt;
`endif

    logic [KW-1:0]    one_k, pos, grp, tw_nxt;
    logic [SW-1:0]    tw_sh;
    logic [LOG2N-1:0] a_nxt, b_nxt;

    // Next-state, stage and butterfly-counter update
    always_comb begin
        state_nxt     = state;
        s_nxt         = s;
        k_nxt         = k;
        stage_en_nxt  = 1'b0;
        stage_rst_nxt = 1'b0;
`ifdef FFT_AG_STAGE_GAP_EN
        gap_nxt       = gap_cnt;
`endif
        case (state)
            IDLE: begin
                if (bus.i_START) begin
                    state_nxt     = RUN;
                    s_nxt         = '0;
                    k_nxt         = '0;
                    stage_rst_nxt = 1'b1;
                end
            end
            RUN: begin
                if (bus.i_READY) begin
                    if (&k) begin
                        k_nxt = '0;
                        if (s == SW'(LOG2N - 1)) begin
                            state_nxt = FIN;
                        end else begin
                            s_nxt        = s + SW'(1);
                            stage_en_nxt = 1'b1;
`ifdef FFT_AG_STAGE_GAP_EN
                            state_nxt    = GAP;
                            gap_nxt      = 8'(GAP_CYCLES - 1);
`endif
                        end
                    end else begin
                        k_nxt = k + KW'(1);
                    end
                end
            end
`ifdef FFT_AG_STAGE_GAP_EN
            GAP: begin
                if (gap_cnt == 8'd0) state_nxt = RUN;
                else                 gap_nxt   = gap_cnt - 8'd1;
            end
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly addresses for the upcoming (s, k); one_k wraps to 0 on the
    // last stage, which turns the pos mask into all-ones as required
    always_comb begin
        one_k  = KW'(1) << s_nxt;
        pos    = k_nxt & (one_k - KW'(1));
        grp    = k_nxt >> s_nxt;
        a_nxt  = (({1'b0, grp} << s_nxt) << 1) | {1'b0, pos};
        b_nxt  = a_nxt | (LOG2N'(1) << s_nxt);
        tw_sh  = SW'(KW) - s_nxt;
        tw_nxt = pos << tw_sh;
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= IDLE;
            s               <= '0;
            k               <= '0;
            bus.o_VALID     <= 1'b0;
            bus.o_ADDR_A    <= '0;
            bus.o_ADDR_B    <= '0;
            bus.o_TW_IDX    <= '0;
            bus.o_STAGE     <= '0;
            bus.o_STAGE_EN  <= 1'b0;
            bus.o_STAGE_RST <= 1'b0;
            bus.o_BUSY      <= 1'b0;
            bus.o_DONE      <= 1'b0;
        end else begin
            state           <= state_nxt;
            s               <= s_nxt;
            k               <= k_nxt;
            bus.o_VALID     <= (state_nxt == RUN);
            bus.o_ADDR_A    <= a_nxt;
            bus.o_ADDR_B    <= b_nxt;
            bus.o_TW_IDX    <= tw_nxt;
            bus.o_STAGE     <= s_nxt;
            bus.o_STAGE_EN  <= stage_en_nxt;
            bus.o_STAGE_RST <= stage_rst_nxt;
            bus.o_BUSY      <= (state_nxt != IDLE);
            bus.o_DONE      <= (state_nxt == FIN);
        end
    end

`ifdef FFT_AG_STAGE_GAP_EN
    // Inter-stage drain counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) gap_cnt <= '0;
        else      gap_cnt <= gap_nxt;
    end
`endif
endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Scoreboard bench for fft_iter_addr_gen (LOG2N=3, GAP_CYCLES=2) with a
// behavioural one-hot stage ring attached to STAGE_EN / STAGE_RST.
module tb_fft_iter_addr_gen;
    localparam int LOG2N = 3;
    localparam int GAPC  = 2;
    localparam int N     = 1 << LOG2N;
`ifdef FFT_AG_STAGE_GAP_EN
    localparam int GAP   = GAPC;
`else
    localparam int GAP   = 0;
`endif
    localparam int TOTAL = LOG2N * N / 2 + (LOG2N - 1) * GAP + 2;

    typedef struct {
        int a;
        int b;
        int tw;
        int s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [LOG2N-1:0] ring;

    fft_iter_addr_gen_if #(.LOG2N(LOG2N)) bus();

    fft_iter_addr_gen #(.LOG2N(LOG2N), .GAP_CYCLES(GAPC)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Downstream ring register model (BITNESS=3, shift left, reset value 1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                ring <= LOG2N'(1);
        else if (bus.o_STAGE_RST)  ring <= LOG2N'(1);
        else if (bus.o_STAGE_EN)   ring <= ring << 1;
    end

    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc, done_cyc, last_hs_cyc;
    int done_cnt, en_cnt, en_total, rst_cnt, hs_cnt, low_cnt;
    bit ring_pend, hold_pend, post_done, finished;
    logic [LOG2N-1:0] hold_a, hold_b;
    logic [LOG2N-2:0] hold_tw;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_expected();
        for (int s = 0; s < LOG2N; s++)
            for (int g = 0; g < N; g += (2 << s))
                for (int p = 0; p < (1 << s); p++)
                    q.push_back('{g + p, g + p + (1 << s), p * ((N / 2) >> s), s});
    endtask

    task automatic clear_counts();
        done_cnt = 0; en_cnt = 0; en_total = 0; rst_cnt = 0; hs_cnt = 0; low_cnt = 0;
        ring_pend = 0; hold_pend = 0; post_done = 0; finished = 0;
        start_cyc = 0; done_cyc = 0; last_hs_cyc = 0;
    endtask

    task automatic sample_cycle();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (bus.i_START && !bus.o_BUSY) start_cyc = cyc;
        if (ring_pend) begin
            chk("ring", 32'(ring), 32'(1) << en_cnt);
            chk("stage_vs_ring", 32'(bus.o_STAGE), en_cnt);
        end
        ring_pend = bus.o_STAGE_EN || bus.o_STAGE_RST;
        if (bus.o_STAGE_RST) begin
            rst_cnt++;
            en_cnt = 0;
            chk("stage_rst_latency", cyc - start_cyc, 1);
        end
        if (bus.o_STAGE_EN) begin
            en_cnt++;
            en_total++;
            chk("stage_en_valid", 32'(bus.o_VALID), (GAP == 0) ? 1 : 0);
        end
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.o_VALID), 1);
            chk("hold_a", 32'(bus.o_ADDR_A), 32'(hold_a));
            chk("hold_b", 32'(bus.o_ADDR_B), 32'(hold_b));
            chk("hold_tw", 32'(bus.o_TW_IDX), 32'(hold_tw));
        end
        hold_pend = bus.o_VALID && !bus.i_READY;
        hold_a = bus.o_ADDR_A;
        hold_b = bus.o_ADDR_B;
        hold_tw = bus.o_TW_IDX;
        if (bus.o_VALID && bus.i_READY) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (q.size() == 0) begin
                chk("extra_handshake", 1, 0);
            end else begin
                e = q.pop_front();
                chk("addr_a", 32'(bus.o_ADDR_A), e.a);
                chk("addr_b", 32'(bus.o_ADDR_B), e.b);
                chk("tw_idx", 32'(bus.o_TW_IDX), e.tw);
                chk("stage", 32'(bus.o_STAGE), e.s);
            end
        end
        if (bus.o_BUSY && !bus.o_VALID && !bus.o_DONE) low_cnt++;
        if (post_done) begin
            chk("busy_fall", 32'(bus.o_BUSY), 0);
            finished = 1;
            post_done = 0;
        end
        if (bus.o_DONE) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_last_hs", cyc - last_hs_cyc, 1);
            post_done = 1;
        end
    endtask

    // mode 0: READY always high; mode 1: 1-high / 2-low READY pattern
    task automatic run_one(input int mode, input bit inject);
        clear_counts();
        push_expected();
        for (int t = 0; t < 400 && !finished; t++) begin
            bus.i_START = (t == 0) || (inject && (t == 2 || t == 5));
            bus.i_READY = (mode == 0) ? 1'b1 : ((t % 3) == 1);
            sample_cycle();
            @(posedge clk);
            #1;
        end
        bus.i_START = 1'b0;
        if (!finished) chk("timeout", 0, 1);
        chk("done_count", done_cnt, 1);
        chk("stage_rst_count", rst_cnt, 1);
        chk("stage_en_count", en_total, LOG2N - 1);
        chk("handshakes", hs_cnt, LOG2N * N / 2);
        chk("queue_empty", q.size(), 0);
        if (mode == 0) begin
            chk("start_to_done", done_cyc - start_cyc + 1, TOTAL);
            chk("valid_low_cycles", low_cnt, (LOG2N - 1) * GAP);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_VALID), 0);
        chk({tag, "_a"}, 32'(bus.o_ADDR_A), 0);
        chk({tag, "_b"}, 32'(bus.o_ADDR_B), 0);
        chk({tag, "_tw"}, 32'(bus.o_TW_IDX), 0);
        chk({tag, "_stage"}, 32'(bus.o_STAGE), 0);
        chk({tag, "_en"}, 32'(bus.o_STAGE_EN), 0);
        chk({tag, "_srst"}, 32'(bus.o_STAGE_RST), 0);
        chk({tag, "_busy"}, 32'(bus.o_BUSY), 0);
        chk({tag, "_done"}, 32'(bus.o_DONE), 0);
    endtask

    initial begin
        bit hit;
        bus.i_START = 1'b0;
        bus.i_READY = 1'b1;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_one(0, 0);
        run_one(1, 0);
        run_one(0, 1);

        // asynchronous reset in stage 1 at k=2 (A=4, B=6)
        clear_counts();
        push_expected();
        hit = 0;
        bus.i_START = 1'b1;
        bus.i_READY = 1'b1;
        sample_cycle();
        @(posedge clk);
        #1 bus.i_START = 1'b0;
        for (int t = 0; t < 100 && !hit; t++) begin
            sample_cycle();
            if (bus.o_VALID && bus.o_STAGE == 1 && bus.o_ADDR_A == 4) hit = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reached_mid_stage1", 32'(hit), 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_rst");
        q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_one(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_iter_addr_gen.md
# fft_iter_addr_gen

Butterfly address and stage sequencer for the iterative radix-2 DIT FFT core. It walks all `LOG2N` stages of an `N = 2^LOG2N` point transform and issues one butterfly per accepted handshake: operand addresses A/B and a twiddle index. It also produces the advance and re-init pulses for the one-hot stage ring shift register. That register sits directly downstream and consumes `o_STAGE_EN` / `o_STAGE_RST` as its `EN` / `RST` inputs.

## Interface
- `LOG2N`, default 10: log2 of transform length; legal range 2..16.
- `GAP_CYCLES`, default 4: idle cycles inserted between stages to let the butterfly pipeline drain; legal range 1..255.
- `CLK`  in  1  clock; all logic is rising-edge.
- `RST`  in  1  reset; asynchronous, active-low.
- `i_START`  in  1  begin a transform; sampled only in IDLE.
- `i_READY`  in  1  butterfly unit accepts the current issue.
- `o_VALID`  out  1  A/B/twiddle outputs are valid.
- `o_ADDR_A`  out  LOG2N  upper-leg operand address.
- `o_ADDR_B`  out  LOG2N  lower-leg operand address, equal to A + 2^s.
- `o_TW_IDX`  out  LOG2N-1  twiddle ROM index.
- `o_STAGE`  out  ceil(log2(LOG2N)) (min 1)  current stage number s.
- `o_STAGE_EN`  out  1  one-cycle pulse at each stage boundary; drives the ring register EN.
- `o_STAGE_RST`  out  1  one-cycle pulse at transform start; drives the ring register RST (active-high).
- `o_BUSY`  out  1  high in every state except IDLE.
- `o_DONE`  out  1  one-cycle pulse after the final butterfly is accepted.

## Operation
- FSM states are IDLE, RUN, GAP and FIN.
- IDLE → RUN on `i_START`. This clears s=0 and k=0 and pulses `o_STAGE_RST`.
- RUN: `o_VALID`=1. A handshake is `o_VALID & i_READY`; each handshake increments k.
  - On a handshake with k = N/2-1 and s < LOG2N-1: k←0, s←s+1, pulse `o_STAGE_EN`, go to GAP.
  - On a handshake with k = N/2-1 and s = LOG2N-1: go to FIN.
- GAP: `o_VALID`=0. A down-counter is loaded with `GAP_CYCLES`; the FSM returns to RUN when the counter reaches 0.
- FIN: pulse `o_DONE`, then go to IDLE. `o_STAGE_EN` does not pulse after the last stage.
- Address arithmetic, with pos = k mod 2^s and grp = k >> s:
  - A = (grp << (s+1)) | pos.
  - B = A | 2^s.
  - TW = pos << (LOG2N-1-s).
  - All are unsigned, computed from registered s and k, with no overflow by construction.
- `i_START` outside IDLE is ignored.
- When `i_READY`=0 in RUN, all outputs hold stable and k does not advance.
- `RST` low at any time (including mid-stage or in GAP) forces IDLE and clears all outputs, s, k and the gap counter.
  - The next transform starts from stage 0.

## Timing
- Reset values: every output is 0, state is IDLE.
- All outputs are registered.
- `i_START` high at edge t gives `o_VALID`=1, `o_STAGE_RST`=1, A=0, B=1 and s=0 in cycle t+1.
- Back-to-back handshakes sustain one butterfly per cycle within a stage.
- `o_STAGE_EN` is high for the single cycle following the last handshake of a stage, coincident with entering GAP. `o_VALID` is low for exactly `GAP_CYCLES` cycles.
- Total cycles from START to DONE with `i_READY`=1 is LOG2N·N/2 + (LOG2N-1)·GAP_CYCLES + 2.
- `o_DONE` is high in the cycle after the final handshake. `o_BUSY` falls one cycle later.

## Configuration
- Macro: `FFT_AG_STAGE_GAP_EN`.
- Defined: the GAP state and counter are compiled in, and `GAP_CYCLES` applies.
- Undefined: the GAP state is removed.
  - RUN continues straight into the next stage; `o_STAGE_EN` pulses in the same cycle as the first butterfly of the new stage, and `o_VALID` stays high.
  - `GAP_CYCLES` is ignored.
  - Total cycles = LOG2N·N/2 + 2.

## Test plan
- Full-run address sequence, LOG2N=3, GAP_CYCLES=2, `i_READY`=1 → exactly 12 handshakes:
  - stage 0: (0,1),(2,3),(4,5),(6,7), TW 0,0,0,0.
  - stage 1: (0,2),(1,3),(4,6),(5,7), TW 0,2,0,2.
  - stage 2: (0,4),(1,5),(2,6),(3,7), TW 0,1,2,3.
  - `o_STAGE_EN` pulses twice, `o_DONE` pulses once, 18 cycles from START to DONE.
- Backpressure, LOG2N=3: toggle `i_READY` with a 1-cycle-high / 2-cycle-low pattern → A/B/TW hold stable while low, the sequence is identical to the full-run case, and no butterfly is skipped or duplicated.
- Stage pulses with the ring register attached (BITNESS=3, shLeft=1, RESET_VALUE=1):
  - ring reads 001 after `o_STAGE_RST`, then 010 and 100 after each `o_STAGE_EN`;
  - `o_STAGE` tracks it as 0, 1, 2.
- `i_START` re-asserted during RUN and GAP → ignored, with no sequence restart and no extra `o_STAGE_RST`.
- `RST` asserted low mid-stage 1 (k=2) → all outputs are 0 asynchronously; a following START begins at stage 0 with A=0, B=1.
- With `FFT_AG_STAGE_GAP_EN` undefined, LOG2N=3 → `o_VALID` stays high for 12 consecutive cycles, `o_DONE` arrives 14 cycles after START, and the addresses match the full-run case.
